// File: rtl/perf_cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perf_cnt_pkg
//  Description : Register map, CTRL bit indices and counter indices shared by
//                the perf_cnt_mmio peripheral and its counter slices.
//  Revision    : 1.0 - initial release
// ============================================================================
package perf_cnt_pkg;

    localparam int c_CNT_W   = 32;
    localparam int c_NUM_CNT = 3;

    localparam logic [2:0] c_OFF_CTRL     = 3'd0;
    localparam logic [2:0] c_OFF_STATUS   = 3'd1;
    localparam logic [2:0] c_OFF_BR_LO    = 3'd2;
    localparam logic [2:0] c_OFF_BR_HI    = 3'd3;
    localparam logic [2:0] c_OFF_HIT_LO   = 3'd4;
    localparam logic [2:0] c_OFF_HIT_HI   = 3'd5;
    localparam logic [2:0] c_OFF_MISPR_LO = 3'd6;
    localparam logic [2:0] c_OFF_MISPR_HI = 3'd7;

    localparam int c_BIT_RUN  = 0;
    localparam int c_BIT_CLR  = 1;
    localparam int c_BIT_SNAP = 2;

    typedef enum logic [1:0] {
        CNT_BR    = 2'd0,
        CNT_HIT   = 2'd1,
        CNT_MISPR = 2'd2
    } cnt_idx_e;

endpackage
`default_nettype wire

// File: rtl/perf_counter.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counter
//  Description : One event counter with clear and run gating. Wraps on
//                overflow by default; saturates when PERF_CNT_SAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_counter
    import perf_cnt_pkg::*;
#(
    parameter int CNT_W = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf_pulse
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_bump;
    logic             w_at_max;

    // A clear in the same cycle swallows the increment, so no overflow either.
    assign w_bump    = run & inc & ~clr;
    assign w_at_max  = &r_cnt;
    assign ovf_pulse = w_bump & w_at_max;
    assign cnt       = r_cnt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (w_bump) begin
`ifdef PERF_CNT_SAT_EN
            if (!w_at_max) begin
                w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
`else
            w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/perf_cnt_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : perf_cnt_mmio
//  Description : Memory-mapped branch-predictor performance counters with
//                run/clear/snapshot control and sticky overflow status.
//                Define PERF_CNT_SAT_EN for saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_cnt_mmio
    import perf_cnt_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hC010,
    parameter int          CNT_W     = c_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        mm_we,
    input  logic        mm_re,
    output logic [15:0] rdata,
    input  logic        inc_br_cnt,
    input  logic        inc_hit_cnt,
    input  logic        inc_mispr_cnt
);

    logic [15:0]      w_off;
    logic             w_sel;
    logic             w_wr;
    logic             w_rd;
    logic             w_ctrl_wr;
    logic             w_sts_wr;
    logic             w_clr;
    logic             w_snap;
    logic [2:0]       w_inc;
    logic [2:0]       w_ovf;
    logic [2:0]       w_sts_clr;
    logic [15:0]      w_rd_mux;
    logic             w_unused;
    logic [CNT_W-1:0] w_cnt [c_NUM_CNT];

    logic             r_run;
    logic [2:0]       r_status;
    logic [15:0]      r_rdata;
    logic [CNT_W-1:0] r_shadow [c_NUM_CNT];

    // Unsigned offset makes addresses below BASE_ADDR wrap far out of window.
    assign w_off     = addr - BASE_ADDR;
    assign w_sel     = (w_off[15:3] == 13'd0);
    assign w_wr      = mm_we & w_sel;
    assign w_rd      = mm_re & w_sel;
    assign w_ctrl_wr = w_wr & (w_off[2:0] == c_OFF_CTRL);
    assign w_sts_wr  = w_wr & (w_off[2:0] == c_OFF_STATUS);
    assign w_clr     = w_ctrl_wr & wdata[c_BIT_CLR];
    assign w_snap    = w_ctrl_wr & wdata[c_BIT_SNAP];
    assign w_sts_clr = w_sts_wr ? wdata[2:0] : 3'b000;
    assign w_inc     = {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt};
    assign w_unused  = ^wdata[15:3];
    assign rdata     = r_rdata;

    perf_counter #(.CNT_W(CNT_W)) u_cnt_br (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_inc[CNT_BR]),
        .clr       (w_clr),
        .run       (r_run),
        .cnt       (w_cnt[CNT_BR]),
        .ovf_pulse (w_ovf[CNT_BR])
    );

    perf_counter #(.CNT_W(CNT_W)) u_cnt_hit (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_inc[CNT_HIT]),
        .clr       (w_clr),
        .run       (r_run),
        .cnt       (w_cnt[CNT_HIT]),
        .ovf_pulse (w_ovf[CNT_HIT])
    );

    perf_counter #(.CNT_W(CNT_W)) u_cnt_mispr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_inc[CNT_MISPR]),
        .clr       (w_clr),
        .run       (r_run),
        .cnt       (w_cnt[CNT_MISPR]),
        .ovf_pulse (w_ovf[CNT_MISPR])
    );

    always_comb begin
        w_rd_mux = 16'h0000;
        case (w_off[2:0])
            c_OFF_CTRL:     w_rd_mux = {15'd0, r_run};
            c_OFF_STATUS:   w_rd_mux = {13'd0, r_status};
            c_OFF_BR_LO:    w_rd_mux = r_shadow[CNT_BR][15:0];
            c_OFF_BR_HI:    w_rd_mux = r_shadow[CNT_BR][31:16];
            c_OFF_HIT_LO:   w_rd_mux = r_shadow[CNT_HIT][15:0];
            c_OFF_HIT_HI:   w_rd_mux = r_shadow[CNT_HIT][31:16];
            c_OFF_MISPR_LO: w_rd_mux = r_shadow[CNT_MISPR][15:0];
            c_OFF_MISPR_HI: w_rd_mux = r_shadow[CNT_MISPR][31:16];
            default:        w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run    <= 1'b1;
            r_status <= 3'b000;
            r_rdata  <= 16'h0000;
            for (int i = 0; i < c_NUM_CNT; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_ctrl_wr) begin
                r_run <= wdata[c_BIT_RUN];
            end
            // New overflow is OR-ed after the clear so a same-cycle set wins.
            r_status <= (r_status & ~w_sts_clr) | w_ovf;
            if (w_snap) begin
                for (int i = 0; i < c_NUM_CNT; i++) begin
                    r_shadow[i] <= w_cnt[i];
                end
            end
            r_rdata <= w_rd ? w_rd_mux : 16'h0000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perf_cnt_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_cnt_mmio
//  Description : Self-checking bench for perf_cnt_mmio: vector table, directed
//                corner cases and random traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_cnt_mmio;

    localparam logic [15:0] BASE = 16'hC010;
    localparam logic [31:0] MAXC = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        mm_we = 1'b0;
    logic        mm_re = 1'b0;
    logic [15:0] rdata;
    logic        inc_br_cnt = 1'b0;
    logic        inc_hit_cnt = 1'b0;
    logic        inc_mispr_cnt = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, in plain software terms.
    bit          m_run;
    longint      m_cnt [3];
    longint      m_shd [3];
    bit   [2:0]  m_sts;

    always #5 clk = ~clk;

    perf_cnt_mmio #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .wdata         (wdata),
        .mm_we         (mm_we),
        .mm_re         (mm_re),
        .rdata         (rdata),
        .inc_br_cnt    (inc_br_cnt),
        .inc_hit_cnt   (inc_hit_cnt),
        .inc_mispr_cnt (inc_mispr_cnt)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input int off);
        int idx;
        if (off == 0) return {15'd0, m_run};
        if (off == 1) return {13'd0, m_sts};
        idx = (off - 2) / 2;
        return 16'((m_shd[idx] >> (16 * ((off - 2) % 2))) & 64'hFFFF);
    endfunction

    // One clock: drive at negedge, advance the model, compare rdata after posedge.
    task automatic step(input logic [15:0] a, input logic we, input logic re,
                        input logic [15:0] wd, input logic [2:0] inc, input logic rst_low);
        int          off;
        bit          inwin;
        logic [15:0] expv;
        bit [2:0]    ovf;
        longint      pre [3];
        @(negedge clk);
        addr = a; mm_we = we; mm_re = re; wdata = wd;
        inc_br_cnt = inc[0]; inc_hit_cnt = inc[1]; inc_mispr_cnt = inc[2];
        rst_n = ~rst_low;

        off   = (int'(a) - int'(BASE) + 65536) % 65536;
        inwin = (off < 8);
        expv  = 16'h0000;
        if (rst_low) begin
            m_run = 1'b1; m_sts = 3'b000;
            for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_shd[k] = 0; end
        end else begin
            if (re && inwin) expv = model_read(off);
            for (int k = 0; k < 3; k++) pre[k] = m_cnt[k];
            ovf = 3'b000;
            if (we && inwin && off == 0 && wd[2]) for (int k = 0; k < 3; k++) m_shd[k] = pre[k];
            for (int k = 0; k < 3; k++) begin
                if (we && inwin && off == 0 && wd[1]) m_cnt[k] = 0;
                else if (m_run && inc[k]) begin
                    if (m_cnt[k] + 1 > longint'(MAXC)) begin
                        ovf[k] = 1'b1;
`ifdef PERF_CNT_SAT_EN
                        m_cnt[k] = longint'(MAXC);
`else
                        m_cnt[k] = 0;
`endif
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
            if (we && inwin && off == 1) m_sts = m_sts & ~wd[2:0];
            m_sts = m_sts | ovf;
            if (we && inwin && off == 0) m_run = wd[0];
        end

        @(posedge clk);
        #1;
        chk("rdata_vs_model", rdata, expv);
    endtask

    task automatic wr(input int off, input logic [15:0] d, input logic [2:0] inc);
        step(BASE + 16'(off), 1'b1, 1'b0, d, inc, 1'b0);
    endtask

    task automatic rd(input int off, input string nm, input logic [15:0] req);
        step(BASE + 16'(off), 1'b0, 1'b1, 16'h0000, 3'b000, 1'b0);
        chk(nm, rdata, req);
    endtask

    task automatic pulse(input logic [2:0] inc, input int n);
        for (int i = 0; i < n; i++) step(BASE, 1'b0, 1'b0, 16'h0000, inc, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  off;
        logic        we;
        logic        re;
        logic [15:0] wd;
        logic [2:0]  inc;
        logic        chk;
        logic [15:0] req;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [15:0] ra;
        logic [15:0] rwd;
        int          r;
        logic [15:0] br_lo_after_ovf;

        tbl[0]  = '{3'd0, 1'b0, 1'b0, 16'h0, 3'b111, 1'b0, 16'h0};
        tbl[1]  = '{3'd0, 1'b0, 1'b0, 16'h0, 3'b111, 1'b0, 16'h0};
        tbl[2]  = '{3'd0, 1'b0, 1'b0, 16'h0, 3'b011, 1'b0, 16'h0};
        tbl[3]  = '{3'd0, 1'b0, 1'b0, 16'h0, 3'b001, 1'b0, 16'h0};
        tbl[4]  = '{3'd0, 1'b0, 1'b0, 16'h0, 3'b001, 1'b0, 16'h0};
        tbl[5]  = '{3'd0, 1'b1, 1'b0, 16'h5, 3'b000, 1'b0, 16'h0};
        tbl[6]  = '{3'd2, 1'b0, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0005};
        tbl[7]  = '{3'd3, 1'b0, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0000};
        tbl[8]  = '{3'd4, 1'b0, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0003};
        tbl[9]  = '{3'd5, 1'b0, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0000};
        tbl[10] = '{3'd6, 1'b0, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0002};
        tbl[11] = '{3'd7, 1'b0, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0000};
        tbl[12] = '{3'd0, 1'b0, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0001};
        tbl[13] = '{3'd1, 1'b0, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0000};
        tbl[14] = '{3'd0, 1'b1, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0001};
        tbl[15] = '{3'd0, 1'b0, 1'b1, 16'h0, 3'b000, 1'b1, 16'h0000};
        tbl[16] = '{3'd0, 1'b1, 1'b0, 16'h1, 3'b000, 1'b0, 16'h0};

        step(BASE, 1'b0, 1'b0, 16'h0, 3'b000, 1'b1);
        step(BASE, 1'b0, 1'b0, 16'h0, 3'b000, 1'b1);
        chk("reset_rdata", rdata, 16'h0000);

        for (int i = 0; i < 17; i++) begin
            step(BASE + 16'(tbl[i].off), tbl[i].we, tbl[i].re, tbl[i].wd, tbl[i].inc, 1'b0);
            if (tbl[i].chk) chk($sformatf("tbl[%0d]", i), rdata, tbl[i].req);
        end

        // Stop/start gating: BR live count is 5 here.
        wr(0, 16'h0000, 3'b000);
        pulse(3'b001, 10);
        wr(0, 16'h0004, 3'b000);
        rd(2, "br_lo_stopped", 16'h0005);
        wr(0, 16'h0001, 3'b000);
        pulse(3'b001, 1);
        wr(0, 16'h0005, 3'b000);
        rd(2, "br_lo_restarted", 16'h0006);

        // Overflow from a preloaded near-max count.
        force dut.u_cnt_br.r_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.u_cnt_br.r_cnt;
        m_cnt[0] = longint'(32'hFFFF_FFFE);
        pulse(3'b001, 3);
        wr(0, 16'h0005, 3'b000);
`ifdef PERF_CNT_SAT_EN
        rd(2, "ovf_br_lo", 16'hFFFF);
        rd(3, "ovf_br_hi", 16'hFFFF);
        br_lo_after_ovf = 16'hFFFF;
`else
        rd(2, "ovf_br_lo", 16'h0001);
        rd(3, "ovf_br_hi", 16'h0000);
        br_lo_after_ovf = 16'h0001;
`endif
        rd(1, "ovf_status", 16'h0001);
        wr(1, 16'h0001, 3'b000);
        rd(1, "status_w1c", 16'h0000);

        // RUN|CLR|SNAP in one write with a concurrent pulse.
        wr(0, 16'h0007, 3'b001);
        rd(2, "snap_pre_clr", br_lo_after_ovf);
        wr(0, 16'h0005, 3'b000);
        rd(2, "after_clr", 16'h0000);

        // Out-of-window accesses.
        step(BASE + 16'd8, 1'b1, 1'b0, 16'h0006, 3'b000, 1'b0);
        step(BASE - 16'd1, 1'b1, 1'b0, 16'h0006, 3'b000, 1'b0);
        step(BASE + 16'd8, 1'b0, 1'b1, 16'h0000, 3'b000, 1'b0);
        chk("oow_plus8", rdata, 16'h0000);
        step(BASE - 16'd1, 1'b0, 1'b1, 16'h0000, 3'b000, 1'b0);
        chk("oow_minus1", rdata, 16'h0000);
        rd(0, "ctrl_after_oow", 16'h0001);

        // Mid-stream reset while a read is in flight.
        pulse(3'b111, 4);
        wr(0, 16'h0004, 3'b000);
        step(BASE + 16'd4, 1'b0, 1'b1, 16'h0000, 3'b111, 1'b1);
        chk("midrst_rdata", rdata, 16'h0000);
        rd(0, "midrst_run", 16'h0001);
        rd(1, "midrst_status", 16'h0000);
        rd(4, "midrst_hit_lo", 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 99));
            ra = BASE + 16'($urandom_range(0, 7));
            if (r < 5)      ra = BASE + 16'd8 + 16'($urandom_range(0, 200));
            else if (r < 8) ra = BASE - 16'd1 - 16'($urandom_range(0, 200));
            rwd = 16'($urandom);
            if (ra == BASE) rwd[0] = ($urandom_range(0, 7) != 0);
            step(ra, ($urandom_range(0, 7) == 0), 1'($urandom), rwd,
                 3'($urandom), ($urandom_range(0, 399) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_cnt_mmio.md
# perf_cnt_mmio

Memory-mapped performance-counter peripheral that sits directly downstream of `cpu`. It counts the CPU's branch-predictor event pulses (`inc_br_cnt`, `inc_hit_cnt`, `inc_mispr_cnt`) in three 32-bit counters. It exposes them to software over the same 16-bit `addr`/`wdata`/`rdata`/`mm_we`/`mm_re` bus the CPU drives. Software can start, stop, clear and atomically snapshot the counters, then read each snapshot as two 16-bit halves.

## Interface
- `BASE_ADDR`, default 16'hC010, word address of register 0; the block decodes `BASE_ADDR` through `BASE_ADDR+7`.
- `CNT_W`, default 32, counter width; fixed at 32 for the register map below.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low, sampled on posedge `clk`.
- `addr`  in  16  CPU memory-mapped address.
- `wdata`  in  16  CPU write data.
- `mm_we`  in  1  write strobe, one cycle per write.
- `mm_re`  in  1  read strobe, one cycle per read.
- `rdata`  out  16  read data; 16'h0000 when not selected (OR-combined bus).
- `inc_br_cnt`, `inc_hit_cnt`, `inc_mispr_cnt`  in  1 each  single-cycle event pulses from `cpu`.

## Operation
- Register map, offset from `BASE_ADDR`:
  - 0 CTRL: bit0 RUN (R/W); bit1 CLR (write-1, self-clearing, reads 0); bit2 SNAP (write-1, self-clearing, reads 0).
  - 1 STATUS: bits[2:0] sticky overflow for br/hit/mispr. Write 1 clears a bit.
  - 2/3 BR snapshot lo/hi; 4/5 HIT snapshot lo/hi; 6/7 MISPR snapshot lo/hi. These are read-only; writes are ignored.
- Live counters:
  - Increment by 1 on a cycle where RUN=1 and the matching `inc_*` is high.
  - The three counters are independent. Simultaneous pulses each count.
- CLR zeroes all three live counters. It does not affect the snapshots or STATUS.
- SNAP copies all three live counters into the shadow registers in one cycle.
- Reads always return shadow values, never live ones. LO/HI pairs are therefore coherent.
- Overflow: when a counter at 32'hFFFF_FFFF receives an increment, its STATUS bit sets. The counter value then follows the Configuration section.
- Same-cycle boundary cases:
  - CLR and increment: CLR wins; counter = 0.
  - SNAP and increment: snapshot takes the pre-increment value.
  - SNAP and CLR in the same write: snapshot takes the pre-clear values.
  - STATUS write-1-clear and new overflow on the same bit: set wins.
  - Write to CTRL with RUN=0 and an increment: the increment in that cycle still counts, because the old RUN applies.
- Accesses outside the 8-word window: no state change, `rdata` = 0.
- Reset values:
  - RUN = 1, so counting starts immediately after reset.
  - Live counters = 0, shadows = 0, STATUS = 0.
  - `rdata` = 16'h0000.
  - Reset asserted mid-operation overrides every other same-cycle event.

## Timing
- Writes take effect on the posedge where `mm_we` is sampled high. The new state is visible the next cycle.
- `rdata` is registered, with one-cycle latency. The value for a read sampled at edge N appears after edge N and is held for one cycle only. After that it returns to 0 unless another in-window read occurs.
- Event-to-count latency: a pulse at edge N is reflected in the live counter after edge N. A SNAP at edge N+1 captures it.
- `mm_we` and `mm_re` both high: the write is performed, and the read returns pre-write state.

## Configuration
- `PERF_CNT_SAT_EN` defined: counters saturate. On overflow the counter holds 32'hFFFF_FFFF and the STATUS bit sets.
- `PERF_CNT_SAT_EN` undefined: counters wrap to 0 on overflow, and the STATUS bit sets.

## Structure
- `perf_cnt_pkg` holds:
  - the register offset localparams: CTRL=0, STATUS=1, BR_LO=2 … MISPR_HI=7;
  - CTRL bit indices: RUN=0, CLR=1, SNAP=2;
  - `CNT_W`;
  - an `enum` for counter index: BR, HIT, MISPR.
- Sub-module `perf_counter`: one 32-bit counter with `inc`, `clr` and `run` inputs, and `cnt` and `ovf_pulse` outputs. It contains the `PERF_CNT_SAT_EN` logic and is instantiated three times. The top level holds decode, CTRL, STATUS, shadows and `rdata`.

## Test plan
- Reset, then 5 `inc_br_cnt`, 3 `inc_hit_cnt` and 2 `inc_mispr_cnt` pulses, then SNAP. Reads of offsets 2,3,4,5,6,7 return 5,0,3,0,2,0, each one cycle after `mm_re`.
- Write CTRL=0 (stop), then 10 br pulses, then SNAP. BR_LO is unchanged. Write CTRL=1, then 1 pulse, then SNAP: BR_LO = previous+1.
- Force the BR counter to 32'hFFFF_FFFE, then 3 pulses, then SNAP.
  - With the macro: BR_HI/LO = FFFF/FFFF and STATUS = 3'b001.
  - Without the macro: BR_HI/LO = 0000/0001 and STATUS = 3'b001.
  - Writing STATUS=1 then reads STATUS = 0.
- A single write CTRL=3'b111 with a concurrent br pulse: the snapshot holds the pre-clear count, and the live counter is 0 afterwards. A following SNAP then reads BR_LO=0.
- Read at `BASE_ADDR+8` and `BASE_ADDR-1`: `rdata` = 0 and no state changes. Assert `rst_n` low for one cycle mid-stream: all registers and `rdata` are 0, and RUN = 1.
